// File: rtl/baw_card_entry.sv
// Card-entry stage for the Black-and-White game: captures and validates each player's card and offers the pair to the comparator.
// Optional colour hint outputs are enabled with `define BAW_COLOR_HINT_EN.
module baw_card_entry #(
    parameter int NUM_CARDS = 9,
    parameter int CW        = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 new_game,
    input  logic                 p1_sel,
    input  logic                 p2_sel,
    input  logic                 commit,
    input  logic [15:0]          sw,
    output logic [CW-1:0]        p1_handcard,
    output logic [CW-1:0]        p2_handcard,
    output logic                 cards_valid,
    input  logic                 cards_ready,
    output logic                 entry_err,
    output logic [NUM_CARDS-1:0] p1_used,
    output logic [NUM_CARDS-1:0] p2_used,
    output logic                 busy_p1,
    output logic                 busy_p2
`ifdef BAW_COLOR_HINT_EN
    ,
    output logic                 p1_color,
    output logic                 p2_color
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        P1_ENTRY = 2'd1,
        P2_ENTRY = 2'd2,
        OFFER    = 2'd3
    } state_t;

    state_t state_r;
    logic   p1Loaded_r;
    logic   p2Loaded_r;

    logic [NUM_CARDS-1:0] selBits_s;
    logic                 selOneHot_s;
    logic [CW-1:0]        selCard_s;
    logic                 p1Accept_s;
    logic                 p2Accept_s;
    logic                 unusedSw_s;

    function automatic logic isOneHot(input logic [NUM_CARDS-1:0] v);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < NUM_CARDS; i++) begin
            cnt = cnt + {4'd0, v[i]};
        end
        return cnt == 5'd1;
    endfunction

    function automatic logic [CW-1:0] cardIndex(input logic [NUM_CARDS-1:0] v);
        logic [CW-1:0] idx;
        idx = {CW{1'b0}};
        for (int i = 0; i < NUM_CARDS; i++) begin
            if (v[i]) begin
                idx = CW'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [NUM_CARDS-1:0] cardMask(input logic [CW-1:0] idx);
        logic [NUM_CARDS-1:0] m;
        for (int i = 0; i < NUM_CARDS; i++) begin
            m[i] = (CW'(i) == idx);
        end
        return m;
    endfunction

    assign selBits_s   = sw[NUM_CARDS-1:0];
    assign selOneHot_s = isOneHot(selBits_s);
    assign selCard_s   = cardIndex(selBits_s);
    assign unusedSw_s  = ^sw;

    // A commit is accepted only for a single, not-yet-played card of the player whose window is open.
    assign p1Accept_s = (state_r == P1_ENTRY) && commit && selOneHot_s
                        && ((selBits_s & p1_used) == {NUM_CARDS{1'b0}});
    assign p2Accept_s = (state_r == P2_ENTRY) && commit && selOneHot_s
                        && ((selBits_s & p2_used) == {NUM_CARDS{1'b0}});

    // Entry FSM with loaded flags, handcards, used masks and all handshake/LED outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            p1Loaded_r  <= 1'b0;
            p2Loaded_r  <= 1'b0;
            p1_handcard <= {CW{1'b0}};
            p2_handcard <= {CW{1'b0}};
            cards_valid <= 1'b0;
            entry_err   <= 1'b0;
            p1_used     <= {NUM_CARDS{1'b0}};
            p2_used     <= {NUM_CARDS{1'b0}};
            busy_p1     <= 1'b0;
            busy_p2     <= 1'b0;
        end else begin
            entry_err <= 1'b0;
            if (new_game) begin
                state_r     <= IDLE;
                p1Loaded_r  <= 1'b0;
                p2Loaded_r  <= 1'b0;
                p1_handcard <= {CW{1'b0}};
                p2_handcard <= {CW{1'b0}};
                cards_valid <= 1'b0;
                p1_used     <= {NUM_CARDS{1'b0}};
                p2_used     <= {NUM_CARDS{1'b0}};
                busy_p1     <= 1'b0;
                busy_p2     <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        // A commit in the same cycle suppresses any select.
                        if (!commit) begin
                            if (p1_sel && !p1Loaded_r) begin
                                state_r <= P1_ENTRY;
                                busy_p1 <= 1'b1;
                            end else if (p2_sel && !p2Loaded_r) begin
                                state_r <= P2_ENTRY;
                                busy_p2 <= 1'b1;
                            end
                        end
                    end
                    P1_ENTRY: begin
                        if (p1Accept_s) begin
                            p1_handcard <= selCard_s;
                            p1Loaded_r  <= 1'b1;
                            busy_p1     <= 1'b0;
                            if (p2Loaded_r) begin
                                state_r     <= OFFER;
                                cards_valid <= 1'b1;
                            end else begin
                                state_r <= IDLE;
                            end
                        end else if (commit) begin
                            entry_err <= 1'b1;
                        end
                    end
                    P2_ENTRY: begin
                        if (p2Accept_s) begin
                            p2_handcard <= selCard_s;
                            p2Loaded_r  <= 1'b1;
                            busy_p2     <= 1'b0;
                            if (p1Loaded_r) begin
                                state_r     <= OFFER;
                                cards_valid <= 1'b1;
                            end else begin
                                state_r <= IDLE;
                            end
                        end else if (commit) begin
                            entry_err <= 1'b1;
                        end
                    end
                    OFFER: begin
                        if (cards_ready) begin
                            p1_used     <= p1_used | cardMask(p1_handcard);
                            p2_used     <= p2_used | cardMask(p2_handcard);
                            p1Loaded_r  <= 1'b0;
                            p2Loaded_r  <= 1'b0;
                            cards_valid <= 1'b0;
                            state_r     <= IDLE;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef BAW_COLOR_HINT_EN
    // Colour hints track the parity of each newly accepted card.
    always_ff @(posedge clk) begin
        if (reset || new_game) begin
            p1_color <= 1'b0;
            p2_color <= 1'b0;
        end else begin
            if (p1Accept_s) begin
                p1_color <= selCard_s[0];
            end
            if (p2Accept_s) begin
                p2_color <= selCard_s[0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_baw_card_entry.sv
// Self-checking bench for baw_card_entry: directed scenarios plus randomized traffic against a behavioural game model.
module tb_baw_card_entry;

    localparam int NC = 9;
    localparam int CW = 4;
    localparam int VW = 2 * CW + 4 + 2 * NC;

    logic          clk = 1'b0;
    logic          reset, new_game, p1_sel, p2_sel, commit, cards_ready;
    logic [15:0]   sw;
    logic [CW-1:0] p1_handcard, p2_handcard;
    logic          cards_valid, entry_err, busy_p1, busy_p2;
    logic [NC-1:0] p1_used, p2_used;
`ifdef BAW_COLOR_HINT_EN
    logic          p1_color, p2_color;
`endif

    int nChecks = 0;
    int nFails  = 0;

    // Behavioural model: which player's window is open, each player's pending card, and sets of played cards.
    int            mOpen;
    bit            mHas1, mHas2;
    int            mCard1, mCard2;
    logic [NC-1:0] mUsed1, mUsed2;
    bit            mErr;

    baw_card_entry #(.NUM_CARDS(NC), .CW(CW)) dut (
        .clk(clk), .reset(reset), .new_game(new_game), .p1_sel(p1_sel), .p2_sel(p2_sel),
        .commit(commit), .sw(sw), .p1_handcard(p1_handcard), .p2_handcard(p2_handcard),
        .cards_valid(cards_valid), .cards_ready(cards_ready), .entry_err(entry_err),
        .p1_used(p1_used), .p2_used(p2_used), .busy_p1(busy_p1), .busy_p2(busy_p2)
`ifdef BAW_COLOR_HINT_EN
        , .p1_color(p1_color), .p2_color(p2_color)
`endif
    );

    always #5 clk = ~clk;

    task automatic modelClear();
        mOpen  = 0;
        mHas1  = 1'b0;
        mHas2  = 1'b0;
        mCard1 = 0;
        mCard2 = 0;
        mUsed1 = '0;
        mUsed2 = '0;
    endtask

    task automatic modelStep();
        int   nSet;
        int   idx;
        logic [NC-1:0] bits;
        bits = sw[NC-1:0];
        nSet = $countones(bits);
        idx  = 0;
        for (int i = 0; i < NC; i++) if (bits[i]) idx = i;
        mErr = 1'b0;
        if (reset || new_game) begin
            modelClear();
        end else if (mOpen == 1) begin
            if (commit) begin
                if (nSet == 1 && !mUsed1[idx]) begin
                    mCard1 = idx; mHas1 = 1'b1; mOpen = 0;
                end else mErr = 1'b1;
            end
        end else if (mOpen == 2) begin
            if (commit) begin
                if (nSet == 1 && !mUsed2[idx]) begin
                    mCard2 = idx; mHas2 = 1'b1; mOpen = 0;
                end else mErr = 1'b1;
            end
        end else if (mHas1 && mHas2) begin
            if (cards_ready) begin
                mUsed1[mCard1] = 1'b1;
                mUsed2[mCard2] = 1'b1;
                mHas1 = 1'b0;
                mHas2 = 1'b0;
            end
        end else if (!commit) begin
            if (p1_sel && !mHas1) mOpen = 1;
            else if (p2_sel && !mHas2) mOpen = 2;
        end
    endtask

    function automatic logic [VW-1:0] expVec();
        return {CW'(mCard1), CW'(mCard2), mHas1 && mHas2, mErr, mOpen == 1, mOpen == 2, mUsed1, mUsed2};
    endfunction

    task automatic cycle(input logic rs, input logic ng, input logic s1, input logic s2,
                         input logic cm, input logic rdy, input logic [15:0] s);
        @(negedge clk);
        reset = rs; new_game = ng; p1_sel = s1; p2_sel = s2; commit = cm; cards_ready = rdy; sw = s;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0, 0, 0, 16'h0000);
        cycle(1, 1, 1, 1, 1, 1, 16'h0010);
        nChecks++;
        if ({p1_handcard, p2_handcard} !== 8'h00) begin
            nFails++; $display("FAIL reset_handcards got %h want 00", {p1_handcard, p2_handcard});
        end
        nChecks++;
        if ({cards_valid, entry_err, busy_p1, busy_p2} !== 4'b0000) begin
            nFails++; $display("FAIL reset_flags got %b want 0000", {cards_valid, entry_err, busy_p1, busy_p2});
        end
        nChecks++;
        if ({p1_used, p2_used} !== 18'h0) begin
            nFails++; $display("FAIL reset_masks got %h want 0", {p1_used, p2_used});
        end
    endtask

    task automatic test_p1_entry();
        cycle(0, 0, 1, 0, 0, 0, 16'h0000);
        nChecks++;
        if (busy_p1 !== 1'b1) begin nFails++; $display("FAIL p1_busy got %b want 1", busy_p1); end
        cycle(0, 0, 0, 0, 1, 0, 16'h0010);
        nChecks++;
        if ({p1_handcard, busy_p1, cards_valid, entry_err} !== {4'd4, 3'b000}) begin
            nFails++; $display("FAIL p1_commit got %h/%b%b%b want 4/000", p1_handcard, busy_p1, cards_valid, entry_err);
        end
    endtask

    task automatic test_full_round();
        cycle(0, 0, 0, 1, 0, 0, 16'h0000);
        cycle(0, 0, 0, 0, 1, 0, 16'h0008);
        nChecks++;
        if ({p2_handcard, cards_valid} !== {4'd3, 1'b1}) begin
            nFails++; $display("FAIL round_offer got %h/%b want 3/1", p2_handcard, cards_valid);
        end
        cycle(0, 0, 0, 0, 0, 1, 16'h0000);
        nChecks++;
        if ({cards_valid, p1_used, p2_used} !== {1'b0, 9'h010, 9'h008}) begin
            nFails++; $display("FAIL round_retire got %b/%h/%h want 0/010/008", cards_valid, p1_used, p2_used);
        end
    endtask

    task automatic test_illegal();
        cycle(0, 0, 1, 0, 0, 0, 16'h0000);
        cycle(0, 0, 0, 0, 1, 0, 16'h0000);
        nChecks++;
        if ({entry_err, busy_p1} !== 2'b11) begin
            nFails++; $display("FAIL illegal_zero got %b%b want 11", entry_err, busy_p1);
        end
        cycle(0, 0, 0, 0, 1, 0, 16'h0006);
        nChecks++;
        if ({entry_err, busy_p1, p1_handcard} !== {2'b11, 4'd4}) begin
            nFails++; $display("FAIL illegal_multi got %b%b/%h want 11/4", entry_err, busy_p1, p1_handcard);
        end
        cycle(0, 0, 0, 0, 0, 0, 16'h0006);
        nChecks++;
        if (entry_err !== 1'b0) begin nFails++; $display("FAIL illegal_pulse got %b want 0", entry_err); end
        cycle(0, 0, 0, 0, 1, 0, 16'h0001);
        nChecks++;
        if ({p1_handcard, busy_p1} !== {4'd0, 1'b0}) begin
            nFails++; $display("FAIL illegal_recover got %h/%b want 0/0", p1_handcard, busy_p1);
        end
        cycle(0, 0, 0, 1, 0, 0, 16'h0000);
        cycle(0, 0, 0, 0, 1, 0, 16'h0001);
        cycle(0, 0, 0, 0, 0, 1, 16'h0000);
    endtask

    task automatic test_reuse();
        cycle(0, 0, 1, 0, 0, 0, 16'h0000);
        cycle(0, 0, 0, 0, 1, 0, 16'h0010);
        nChecks++;
        if ({entry_err, busy_p1, p1_used} !== {2'b11, 9'h011}) begin
            nFails++; $display("FAIL reuse got %b%b/%h want 11/011", entry_err, busy_p1, p1_used);
        end
        cycle(0, 0, 0, 0, 1, 0, 16'h0020);
    endtask

    task automatic test_newgame_offer();
        cycle(0, 0, 0, 1, 0, 0, 16'h0000);
        cycle(0, 0, 0, 0, 1, 0, 16'h0002);
        nChecks++;
        if (cards_valid !== 1'b1) begin nFails++; $display("FAIL ng_offer got %b want 1", cards_valid); end
        cycle(0, 1, 0, 0, 0, 1, 16'h0000);
        nChecks++;
        if ({cards_valid, p1_handcard, p2_handcard, p1_used, p2_used} !== 27'h0) begin
            nFails++; $display("FAIL ng_clear got %b/%h/%h/%h/%h want all 0",
                               cards_valid, p1_handcard, p2_handcard, p1_used, p2_used);
        end
    endtask

    task automatic test_exhaustion();
        for (int r = 0; r < NC; r++) begin
            cycle(0, 0, 1, 0, 0, 0, 16'h0000);
            cycle(0, 0, 0, 0, 1, 0, 16'(1 << r));
            cycle(0, 0, 0, 1, 0, 0, 16'h0000);
            cycle(0, 0, 0, 0, 1, 0, 16'(1 << (NC - 1 - r)));
            cycle(0, 0, 0, 0, 0, 1, 16'h0000);
            nChecks++;
            if ({p1_used, p2_used} !== {mUsed1, mUsed2}) begin
                nFails++; $display("FAIL exhaust_round%0d got %h/%h want %h/%h", r, p1_used, p2_used, mUsed1, mUsed2);
            end
        end
        nChecks++;
        if ({p1_used, p2_used} !== {9'h1FF, 9'h1FF}) begin
            nFails++; $display("FAIL exhaust_full got %h/%h want 1ff/1ff", p1_used, p2_used);
        end
        cycle(0, 0, 1, 0, 0, 0, 16'h0000);
        cycle(0, 0, 0, 0, 1, 0, 16'h0100);
        nChecks++;
        if (entry_err !== 1'b1) begin nFails++; $display("FAIL exhaust_err got %b want 1", entry_err); end
        cycle(0, 1, 0, 0, 0, 0, 16'h0000);
        nChecks++;
        if ({p1_used, busy_p1} !== 10'h0) begin
            nFails++; $display("FAIL exhaust_newgame got %h/%b want 0/0", p1_used, busy_p1);
        end
        cycle(0, 0, 1, 0, 0, 0, 16'h0000);
        cycle(0, 0, 0, 0, 1, 0, 16'h0100);
        nChecks++;
        if ({p1_handcard, entry_err} !== {4'd8, 1'b0}) begin
            nFails++; $display("FAIL exhaust_card8 got %h/%b want 8/0", p1_handcard, entry_err);
        end
    endtask

    task automatic test_random();
        logic [15:0] s;
        cycle(0, 1, 0, 0, 0, 0, 16'h0000);
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 9) < 7) s = 16'(1 << $urandom_range(0, NC - 1)) | 16'($urandom() & 32'hFE00);
            else s = 16'($urandom());
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 79) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, s);
            nChecks++;
            if ({p1_handcard, p2_handcard, cards_valid, entry_err, busy_p1, busy_p2, p1_used, p2_used} !== expVec()) begin
                nFails++;
                $display("FAIL random_cycle%0d got %h want %h", n,
                         {p1_handcard, p2_handcard, cards_valid, entry_err, busy_p1, busy_p2, p1_used, p2_used}, expVec());
            end
`ifdef BAW_COLOR_HINT_EN
            nChecks++;
            if ({p1_color, p2_color} !== {p1_handcard[0], p2_handcard[0]}) begin
                nFails++; $display("FAIL random_color%0d got %b%b want %b%b", n, p1_color, p2_color,
                                   p1_handcard[0], p2_handcard[0]);
            end
`endif
        end
    endtask

    initial begin
        reset = 1'b1; new_game = 1'b0; p1_sel = 1'b0; p2_sel = 1'b0;
        commit = 1'b0; cards_ready = 1'b0; sw = 16'h0000;
        modelClear();
        mErr = 1'b0;
        test_reset();
        test_p1_entry();
        test_full_round();
        test_illegal();
        test_reuse();
        test_newgame_offer();
        test_exhaustion();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/baw_card_entry.md
Name: baw_card_entry

Overview:
- Upstream card-entry stage for the Black-and-White game datapath. It sits between the debounced button/switch inputs and the match comparator.
- Captures each player's hand card from the switch bank and rejects illegal selections (non-one-hot, or a card already played this game).
- Holds both cards until the comparator accepts them, then retires them into per-player used-card masks.
- Supplies p1_handcard/p2_handcard and a valid/ready handshake to the comparator.

Parameters:
- NUM_CARDS, 9, cards per player; legal values 0..NUM_CARDS-1; max 16.
- CW, 4, card value width; must satisfy 2^CW >= NUM_CARDS.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- new_game  in  1  one-cycle pulse: clear used masks and pending cards
- p1_sel  in  1  one-cycle pulse (btnLeft): open P1 entry
- p2_sel  in  1  one-cycle pulse (btnRight): open P2 entry
- commit  in  1  one-cycle pulse (btnTop): latch switch selection
- sw  in  16  switch bank; sw[NUM_CARDS-1:0] one-hot card select; upper bits ignored
- p1_handcard  out  CW  latched P1 card
- p2_handcard  out  CW  latched P2 card
- cards_valid  out  1  both cards latched, offered to comparator
- cards_ready  in  1  comparator accepts (one-cycle pulse)
- entry_err  out  1  one-cycle pulse on rejected commit
- p1_used  out  NUM_CARDS  P1 played-card mask
- p2_used  out  NUM_CARDS  P2 played-card mask
- busy_p1, busy_p2  out  1  entry window open for that player (LED hint)

Behaviour:
- All outputs are registered. After reset: handcards 0, masks 0, cards_valid 0, entry_err 0, busy_* 0, FSM in IDLE.
- FSM states: IDLE, P1_ENTRY, P2_ENTRY, OFFER.
- IDLE:
  - p1_sel with P1 not yet loaded -> P1_ENTRY.
  - p2_sel with P2 not yet loaded -> P2_ENTRY.
  - Both pulses in the same cycle -> P1 wins.
  - sel for an already-loaded player is ignored.
- P1_ENTRY / P2_ENTRY:
  - busy_x = 1.
  - commit with sw[NUM_CARDS-1:0] exactly one-hot AND the corresponding used bit clear: handcard <= index of the set bit, loaded flag set.
    - If the other player is also loaded -> OFFER; otherwise -> IDLE.
  - commit otherwise (zero bits, more than one bit, or card already used): entry_err = 1 for the next cycle; stay in the state; handcard unchanged.
  - p1_sel/p2_sel while in an entry state are ignored.
- OFFER:
  - cards_valid = 1; handcards stable.
  - cards_ready -> set p1_used[p1_handcard] and p2_used[p2_handcard]; clear loaded flags; cards_valid 0 on the next cycle; -> IDLE.
  - cards_ready while not in OFFER is ignored.
- Latency: commit to handcard update = 1 cycle. Second commit to cards_valid = 1 cycle.
- Masks full (all NUM_CARDS bits set): every commit errs; no wrap-around. new_game is required to clear.
- new_game in any state: masks, loaded flags and handcards cleared; -> IDLE next cycle. It takes priority over commit/cards_ready in the same cycle.
- reset takes priority over everything, including new_game.
- Commit and select in the same cycle: commit is processed, select is ignored.

Optional Feature:
- Macro: BAW_COLOR_HINT_EN.
- Defined: adds outputs p1_color and p2_color (1 bit each, registered).
  - Value = handcard[0] (1 = white/odd, 0 = black/even).
  - Valid from the cycle after the commit; held until retire; 0 after reset/new_game.
- Undefined: ports absent; no extra logic.

Test Plan:
- Reset then P1 entry: reset 2 cycles; p1_sel, sw=16'h0010, commit -> p1_handcard=4, busy_p1=0 next cycle, cards_valid=0, entry_err=0.
- Full round: as above, then p2_sel, sw=16'h0008, commit -> p2_handcard=3, cards_valid=1. cards_ready pulse -> cards_valid=0, p1_used=9'h010, p2_used=9'h008.
- Illegal select: p1_sel; commit with sw=16'h0000, then sw=16'h0006 -> entry_err pulses twice, state stays P1_ENTRY. Then sw=16'h0001, commit -> p1_handcard=0.
- Reuse rejection: after P1 has played card 4, p1_sel, sw=16'h0010, commit -> entry_err=1, p1_used unchanged.
- new_game during OFFER with cards_ready in the same cycle -> masks 0, cards_valid 0, handcards 0, no used bits set.
- Exhaustion: play all 9 cards for both players via 9 rounds; then any P1 commit -> entry_err=1. new_game -> p1_used=0; a commit with card 8 is accepted.
